// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial add sequencer and its slice adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Bits needed to count `value` items, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
module serial_add_slice #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s       = total_s[W-1:0];
  assign cout    = total_s[W];

endmodule

// File: rtl/serial_add_sequencer.sv
// Streams N-bit operands through a W-bit slice adder, LSB slice first,
// owning the inter-slice carry and reporting the final carry-out.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int N = 1024,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_slice,
  input  logic [W-1:0] b_slice,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_slice,
  output logic         cout
);

  localparam int CC = N / W;
  localparam int CW = clog2(CC);
  localparam logic [CW-1:0] LAST_CNT = CW'(CC - 1);

  state_e        state_q, state_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cout_q, cout_d;

  logic [W-1:0]  slice_sum_s;
  logic          slice_cout_s;
  logic          in_hs_s;
  logic          out_hs_s;

  serial_add_slice #(.W(W)) u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // A held output slice blocks new input so sum and carry stay frozen.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_hs_s  = in_valid && in_ready;
  assign out_hs_s = out_valid_q && out_ready;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cout_d      = cout_q;
    case (state_q)
      IDLE: begin
        carry_d = 1'b0;
        cnt_d   = '0;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cout_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s) begin
          sum_d       = slice_sum_s;
          carry_d     = slice_cout_s;
          out_valid_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            cout_d  = slice_cout_s;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (out_hs_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      FLUSH: begin
        if (out_hs_s) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d     = IDLE;
        carry_d     = 1'b0;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cout_q      <= cout_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign sum_slice = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer (N=8 and N=1024 instances).
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] a_slice = 2'd0, b_slice = 2'd0;
  logic       busy, done, in_ready, out_valid, cout;
  logic [1:0] sum_slice;

  logic       l_start = 1'b0, l_in_valid = 1'b0, l_out_ready = 1'b0;
  logic [1:0] l_a_slice = 2'd0, l_b_slice = 2'd0;
  logic       l_busy, l_done, l_in_ready, l_out_valid, l_cout;
  logic [1:0] l_sum_slice;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.N(8), .W(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_slice(a_slice), .b_slice(b_slice),
    .out_valid(out_valid), .out_ready(out_ready), .sum_slice(sum_slice), .cout(cout)
  );

  serial_add_sequencer #(.N(1024), .W(2)) u_dut_big (
    .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .a_slice(l_a_slice), .b_slice(l_b_slice),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .sum_slice(l_sum_slice), .cout(l_cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_sum"}, sum_slice, 2'd0);
    check({tag, "_cout"}, cout, 1'b0);
  endtask

  // One N=8 operation, begun in the current cycle; returns in the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input int p_in, input int p_out,
                     input int in_after, input int in_len,
                     input int out_after, input int out_len,
                     input bit spam, input int exp_done);
    logic [8:0] ref_sum;
    logic [7:0] got;
    logic [7:0] a_sh, b_sh;
    logic [1:0] prev_sum;
    int in_idx, out_idx, in_stall, out_stall;
    bit prev_stall, finished;
    ref_sum = {1'b0, a} + {1'b0, b};
    got = 8'd0; in_idx = 0; out_idx = 0; in_stall = 0; out_stall = 0;
    prev_stall = 1'b0; prev_sum = 2'd0; finished = 1'b0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 200 && !finished; c++) begin
      if (done) begin
        finished = 1'b1;
        check("slice_count", out_idx, 4);
        check("sum", got, ref_sum[7:0]);
        check("cout", cout, ref_sum[8]);
        check("busy_at_done", busy, 1'b0);
        if (exp_done >= 0) check("done_cycle", c, exp_done);
      end else begin
        check("busy", busy, 1'b1);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_sum", sum_slice, prev_sum);
        end
        a_sh = a >> (2 * in_idx);
        b_sh = b >> (2 * in_idx);
        a_slice   = a_sh[1:0];
        b_slice   = b_sh[1:0];
        in_valid  = (in_idx < 4) && (in_stall == 0) && ($urandom_range(99) < p_in);
        out_ready = (out_stall == 0) && ($urandom_range(99) < p_out);
        if (in_stall > 0) in_stall--;
        if (out_stall > 0) out_stall--;
        start = spam ? 1'($urandom_range(1)) : 1'b0;
        #1;
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 1'b0);
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum_slice;
        if (in_valid && in_ready) begin
          in_idx++;
          if (in_idx == in_after) in_stall = in_len;
        end
        if (out_valid && out_ready) begin
          if (out_idx < 4) got[2*out_idx +: 2] = sum_slice;
          out_idx++;
          if (out_idx == out_after) out_stall = out_len;
        end
        @(posedge clk); #1;
      end
    end
    if (!finished) check("done_timeout", 1'b0, 1'b1);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int big_idx, big_out, big_done;
    #1;
    check_all_zero("reset");
    check("reset_big_busy", l_busy, 1'b0);
    check("reset_big_out_valid", l_out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    idle_cycle();

    // Test 1: continuous flow, 0x5A + 0x3C
    op8(8'h5A, 8'h3C, 100, 100, 0, 0, 0, 0, 1'b0, 6);
    idle_cycle();
    check("after_done_low", done, 1'b0);
    check("cout_held", cout, 1'b0);
    check("busy_idle", busy, 1'b0);

    // Test 2: carry out, then back-to-back start in the done cycle
    op8(8'hFF, 8'h01, 100, 100, 0, 0, 0, 0, 1'b0, 6);
    op8(8'h00, 8'h00, 100, 100, 0, 0, 0, 0, 1'b0, 6);
    idle_cycle();

    // Test 3: output stall of 3 cycles after second output slice
    op8(8'h5A, 8'h3C, 100, 100, 0, 0, 2, 3, 1'b0, 9);
    idle_cycle();

    // Test 4: input gap of 2 cycles after slice 1, spurious start pulses
    op8(8'h5A, 8'h3C, 100, 100, 1, 2, 0, 0, 1'b1, 8);
    idle_cycle();

    // Test 5: reset while slice 2 is accepted
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a_slice = 2'd2; b_slice = 2'd0;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1'b1);
    a_slice = 2'd2; b_slice = 2'd3;
    #1; rst = 1'b1; #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no_done_after_reset", done, 1'b0);
      check("idle_after_reset", busy, 1'b0);
      idle_cycle();
    end
    op8(8'hFF, 8'h01, 100, 100, 0, 0, 0, 0, 1'b0, 6);
    idle_cycle();

    // Randomized operations with random flow control and chaining
    for (int k = 0; k < 16; k++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(40, 100)),
          int'($urandom_range(40, 100)), 0, 0, 0, 0, 1'($urandom_range(1)), -1);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();

    // Test 6: N=1024, all ones + 1, continuous flow
    big_idx = 0; big_out = 0; big_done = -1;
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    for (int c = 1; c < 700 && big_done < 0; c++) begin
      if (l_done) begin
        big_done = c;
      end else begin
        check("big_busy", l_busy, 1'b1);
        l_in_valid  = (big_idx < 512);
        l_a_slice   = 2'd3;
        l_b_slice   = (big_idx == 0) ? 2'd1 : 2'd0;
        l_out_ready = 1'b1;
        #1;
        if (l_in_valid && l_in_ready) big_idx++;
        if (l_out_valid && l_out_ready) begin
          check("big_slice", l_sum_slice, 2'd0);
          big_out++;
        end
        @(posedge clk); #1;
      end
    end
    check("big_done_cycle", big_done, 514);
    check("big_slice_count", big_out, 512);
    check("big_cout", l_cout, 1'b1);
    check("big_busy_at_done", l_busy, 1'b0);
    l_in_valid = 1'b0; l_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Sequences a W-bit-per-cycle serial adder over N-bit operands streamed LSB-slice-first, taking CC = N/W cycles. The block owns the inter-slice carry: clears it at operation start, holds it during stalls, and reports the final carry-out.
It sits between the operand/label streaming front end and the downstream result collector. Flow control is valid/ready on both sides, with a start/busy/done control pair.

Parameters:
N, 1024, total operand width in bits; must be a multiple of W.
W, 2, slice width in bits per accepted cycle; CC = N/W is a derived localparam.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin an operation; honoured only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final output slice handshake
in_valid  input  1  a_slice/b_slice valid
in_ready  output  1  sequencer accepts a slice this cycle
a_slice  input  W  operand A slice, LSB slice first
b_slice  input  W  operand B slice, LSB slice first
out_valid  output  1  sum_slice valid
out_ready  input  1  downstream accepts sum_slice
sum_slice  output  W  sum slice, LSB slice first
cout  output  1  final carry-out; valid while done is high, held until next start

Behaviour:
- Reset (async, rst=1): state=IDLE, carry=0, slice counter=0. busy, done, in_ready, out_valid, sum_slice and cout are all 0. Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 moves to RUN at the next edge.
  - carry and counter are cleared.
  - cout is cleared on the start edge.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Input handshake: in_valid && in_ready.
  - On a handshake, {carry, sum_slice} <= a_slice + b_slice + carry, computed at W+1 bits. out_valid<=1 and counter increments.
  - If out_valid && out_ready and there is no new input handshake, out_valid<=0.
  - Handshake with counter==CC-1: cout<=carry result, then go to FLUSH. in_ready is 0 in FLUSH.
- FLUSH: when out_valid && out_ready, out_valid<=0, done<=1 for one cycle, and go to IDLE.
- Stall rules:
  - While out_valid && !out_ready: sum_slice, carry and counter are frozen and in_ready=0.
  - in_valid low: no state change.
- Throughput and latency, with in_valid and out_ready held high:
  - Start accepted at cycle 0; slices are accepted in cycles 1..CC.
  - out_valid is high in cycles 2..CC+1.
  - done pulses in cycle CC+2; busy is high in cycles 1..CC+1.
- start while busy or in FLUSH is ignored.
- Wrap: the counter returns to 0 on the IDLE entry. There is no carry leak between operations.
- Back-to-back operations: start may be asserted in the same cycle as done and is accepted, because the state is already IDLE.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum {IDLE, RUN, FLUSH};
  - function clog2 for counter width (counter width = clog2(CC), minimum 1).
- One sub-module: serial_add_slice. It is purely combinational: inputs a[W], b[W], cin; outputs s[W], cout.
- The sequencer holds all registers (carry, counter, output register, FSM).

Test Plan:
1. N=8, W=2; a=0x5A (slices 2,2,1,1), b=0x3C (slices 0,3,3,0); in_valid and out_ready tied high -> sum slices 2,1,1,2 (0x96), cout=0, done at cycle 6.
2. N=8, W=2; a=0xFF, b=0x01 -> sum slices 0,0,0,0, cout=1. Immediately followed by a=0x00, b=0x00 with start in the done cycle -> slices 0,0,0,0, cout=0 (carry cleared).
3. N=8, W=2; operands as in test 1, with out_ready low for 3 cycles after the second output slice:
   - in_ready=0 for those cycles;
   - sum_slice is held at 1 and carry is unchanged;
   - the final result is still 0x96, and done is delayed 3 cycles, to cycle 9.
4. N=8, W=2; in_valid deasserted 2 cycles between slices 1 and 2 -> no counter advance, correct 0x96, done delayed 2 cycles; start pulses during RUN and FLUSH have no effect.
5. Assert rst during the cycle slice 2 is accepted -> all outputs 0 asynchronously, state IDLE, no done. A fresh start with a=0xFF, b=0x01 then yields 0x00 with cout=1.
6. Defaults N=1024, W=2; a=all ones, b=1, continuous flow -> 512 slices all 0, cout=1, done at cycle 514, busy high in cycles 1..513.
